// File: rtl/hood_mode_ctrl.sv
// Range-hood mode controller: N speed levels with a timed hurricane burst on the top level,
// a timed self-clean mode, and the shared per-second prescaler behind both countdowns.
module hood_mode_ctrl #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned NUM_LEVELS = 3,
  parameter int unsigned TOP_SECS   = 60,
  parameter int unsigned CLEAN_SECS = 180,
  parameter int unsigned LW         = $clog2(NUM_LEVELS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  power_on,
  input  logic                  menu_btn,
  input  logic [NUM_LEVELS-1:0] level_btn,
  input  logic                  clean_btn,
  input  logic                  top_allowed,
  output logic [LW-1:0]         level,
  output logic                  cleaning,
  output logic                  menu_armed,
  output logic [7:0]            secs_left,
  output logic [NUM_LEVELS+1:0] led,
  output logic                  done_pulse
);

  localparam int unsigned    PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned    LEDW      = $clog2(NUM_LEVELS + 2);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [LW-1:0]  TOP_LEVEL = LW'(NUM_LEVELS);
  localparam logic [LW-1:0]  SUB_LEVEL = LW'(NUM_LEVELS - 1);

  typedef enum logic [2:0] {StOff, StStandby, StRun, StHurricane, StClean} state_e;

  state_e                  state_q, state_d;
  logic [LW-1:0]           run_lvl_q, run_lvl_d;
  logic                    armed_q, armed_d;
  logic                    ret_q, ret_d;
  logic                    done_q, done_d;
  logic [7:0]              secs_q, secs_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic                    menu_prev_q, clean_prev_q;
  logic [NUM_LEVELS-1:0]   level_prev_q;
  logic [LW-1:0]           level_q, level_d;
  logic [NUM_LEVELS+1:0]   led_q, led_d;
  logic                    cleaning_q, cleaning_d;

  logic                    menu_edge, clean_edge;
  logic [NUM_LEVELS-1:0]   level_edge, sb_mask, run_mask;
  logic [LW-1:0]           sb_pick, run_pick;
  logic                    tick, expire;

  // Returns the 1-based level of the lowest set bit, or 0 when none is set.
  function automatic logic [LW-1:0] lowest_level(input logic [NUM_LEVELS-1:0] m);
    logic [LW-1:0] r;
    r = '0;
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      if (m[i]) r = LW'(i + 1);
    end
    return r;
  endfunction

  // Button edges, candidate level selections and the one-second tick.
  always_comb begin
    menu_edge  = menu_btn & ~menu_prev_q;
    clean_edge = clean_btn & ~clean_prev_q;
    level_edge = level_btn & ~level_prev_q;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      // The top level is only a candidate from standby, and only while permitted.
      sb_mask[i]  = level_edge[i] & ((i != NUM_LEVELS - 1) | top_allowed);
      run_mask[i] = level_edge[i] & (i != NUM_LEVELS - 1) & (LW'(i + 1) != run_lvl_q);
    end
    sb_pick  = lowest_level(sb_mask);
    run_pick = lowest_level(run_mask);
    tick     = (presc_q == PRESC_MAX);
    expire   = tick & (secs_q == 8'd1);
  end

  // Next-state logic for the mode FSM, its timers and the menu/return flags.
  always_comb begin
    state_d   = state_q;
    run_lvl_d = run_lvl_q;
    armed_d   = armed_q;
    ret_d     = ret_q;
    secs_d    = secs_q;
    presc_d   = presc_q;
    done_d    = 1'b0;

    if ((state_q == StHurricane) || (state_q == StClean)) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    if (!power_on) begin
      state_d   = StOff;
      run_lvl_d = '0;
      armed_d   = 1'b0;
      ret_d     = 1'b0;
      secs_d    = '0;
      presc_d   = '0;
    end else begin
      unique case (state_q)
        StOff: state_d = StStandby;
        StStandby: begin
          if (armed_q && (sb_pick != '0)) begin
            armed_d = 1'b0;
            if (sb_pick == TOP_LEVEL) begin
              state_d = StHurricane;
              secs_d  = 8'(TOP_SECS);
              presc_d = '0;
              ret_d   = 1'b0;
            end else begin
              state_d   = StRun;
              run_lvl_d = sb_pick;
            end
          end else if (armed_q && clean_edge) begin
            armed_d = 1'b0;
            state_d = StClean;
            secs_d  = 8'(CLEAN_SECS);
            presc_d = '0;
          end else if (menu_edge) begin
            armed_d = ~armed_q;
          end
        end
        StRun: begin
          if (armed_q) begin
            state_d   = StStandby;
            run_lvl_d = '0;
            armed_d   = 1'b0;
          end else begin
            if (run_pick != '0) run_lvl_d = run_pick;
            if (menu_edge) armed_d = 1'b1;
          end
        end
        StHurricane: begin
          // A menu press in the expiry cycle still counts toward the return.
          ret_d = ret_q | menu_edge;
          if (!top_allowed || expire) begin
            state_d   = ret_d ? StRun : StStandby;
            run_lvl_d = ret_d ? SUB_LEVEL : '0;
            done_d    = top_allowed;
            ret_d     = 1'b0;
            secs_d    = '0;
            presc_d   = '0;
          end else if (tick) begin
            secs_d = secs_q - 8'd1;
          end
        end
        StClean: begin
          if (expire) begin
            state_d = StStandby;
            done_d  = 1'b1;
            secs_d  = '0;
            presc_d = '0;
          end else if (tick) begin
            secs_d = secs_q - 8'd1;
          end
        end
        default: state_d = StOff;
      endcase
    end
  end

  // Decode the displayed outputs from the next state so they can be registered.
  always_comb begin
    level_d    = '0;
    led_d      = '0;
    cleaning_d = 1'b0;
    unique case (state_d)
      StOff: ;
      StStandby: led_d[0] = 1'b1;
      StRun: begin
        level_d                  = run_lvl_d;
        led_d[LEDW'(run_lvl_d)]  = 1'b1;
      end
      StHurricane: begin
        level_d           = TOP_LEVEL;
        led_d[NUM_LEVELS] = 1'b1;
      end
      StClean: begin
        cleaning_d            = 1'b1;
        led_d[NUM_LEVELS + 1] = 1'b1;
      end
      default: ;
    endcase
  end

  // State, timers, edge history and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StOff;
      run_lvl_q    <= '0;
      armed_q      <= 1'b0;
      ret_q        <= 1'b0;
      done_q       <= 1'b0;
      secs_q       <= '0;
      presc_q      <= '0;
      menu_prev_q  <= 1'b0;
      clean_prev_q <= 1'b0;
      level_prev_q <= '0;
      level_q      <= '0;
      led_q        <= '0;
      cleaning_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_lvl_q    <= run_lvl_d;
      armed_q      <= armed_d;
      ret_q        <= ret_d;
      done_q       <= done_d;
      secs_q       <= secs_d;
      presc_q      <= presc_d;
      menu_prev_q  <= menu_btn;
      clean_prev_q <= clean_btn;
      level_prev_q <= level_btn;
      level_q      <= level_d;
      led_q        <= led_d;
      cleaning_q   <= cleaning_d;
    end
  end

  assign level      = level_q;
  assign cleaning   = cleaning_q;
  assign menu_armed = armed_q;
  assign secs_left  = secs_q;
  assign led        = led_q;
  assign done_pulse = done_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Bench for hood_mode_ctrl: directed scenarios plus random button traffic, all checked
// cycle by cycle through a scoreboard fed by a cycle-count based reference model.
module tb_hood_mode_ctrl;

  localparam int unsigned CLK_HZ = 10;
  localparam int unsigned N      = 3;
  localparam int unsigned TOP    = 3;
  localparam int unsigned CLEAN  = 5;
  localparam int unsigned LW     = $clog2(N + 1);

  localparam int M_OFF = 0, M_STBY = 1, M_RUN = 2, M_TOP = 3, M_CLEAN = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          power_on = 1'b0;
  logic          menu_btn = 1'b0;
  logic [N-1:0]  level_btn = '0;
  logic          clean_btn = 1'b0;
  logic          top_allowed = 1'b0;
  logic [LW-1:0] level;
  logic          cleaning, menu_armed, done_pulse;
  logic [7:0]    secs_left;
  logic [N+1:0]  led;

  hood_mode_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .NUM_LEVELS(N),
    .TOP_SECS  (TOP),
    .CLEAN_SECS(CLEAN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .power_on   (power_on),
    .menu_btn   (menu_btn),
    .level_btn  (level_btn),
    .clean_btn  (clean_btn),
    .top_allowed(top_allowed),
    .level      (level),
    .cleaning   (cleaning),
    .menu_armed (menu_armed),
    .secs_left  (secs_left),
    .led        (led),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LW-1:0] level;
    logic          cleaning;
    logic          armed;
    logic [7:0]    secs;
    logic [N+1:0]  led;
    logic          done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, mon_a;
  int   tests = 0;
  int   fails = 0;

  // Reference model: mode, level, and remaining time counted in raw clock cycles.
  int     m_mode = M_OFF, m_lvl = 0, m_cyc = 0;
  bit     m_armed = 0, m_ret = 0, m_done = 0;
  bit     p_menu = 0, p_clean = 0;
  bit [N-1:0] p_lvl = '0;

  task automatic model_step();
    bit menu_e, clean_e;
    bit [N-1:0] lvl_e;
    int pick;
    if (!rst) begin
      m_mode = M_OFF; m_lvl = 0; m_cyc = 0; m_armed = 0; m_ret = 0; m_done = 0;
      p_menu = 0; p_clean = 0; p_lvl = '0;
      return;
    end
    menu_e  = menu_btn && !p_menu;
    clean_e = clean_btn && !p_clean;
    lvl_e   = level_btn & ~p_lvl;
    p_menu  = menu_btn;
    p_clean = clean_btn;
    p_lvl   = level_btn;
    m_done  = 0;
    if (!power_on) begin
      m_mode = M_OFF; m_lvl = 0; m_cyc = 0; m_armed = 0; m_ret = 0;
      return;
    end
    case (m_mode)
      M_OFF: m_mode = M_STBY;
      M_STBY: begin
        pick = 0;
        for (int k = 1; k <= N; k++)
          if (pick == 0 && lvl_e[k-1] && (k < N || top_allowed)) pick = k;
        if (m_armed && pick != 0) begin
          m_armed = 0;
          if (pick == N) begin m_mode = M_TOP; m_cyc = TOP * CLK_HZ; m_ret = 0; end
          else begin m_mode = M_RUN; m_lvl = pick; end
        end else if (m_armed && clean_e) begin
          m_armed = 0; m_mode = M_CLEAN; m_cyc = CLEAN * CLK_HZ;
        end else if (menu_e) begin
          m_armed = !m_armed;
        end
      end
      M_RUN: begin
        if (m_armed) begin
          m_mode = M_STBY; m_lvl = 0; m_armed = 0;
        end else begin
          pick = 0;
          for (int k = 1; k < N; k++)
            if (pick == 0 && lvl_e[k-1] && k != m_lvl) pick = k;
          if (pick != 0) m_lvl = pick;
          if (menu_e) m_armed = 1;
        end
      end
      M_TOP: begin
        if (menu_e) m_ret = 1;
        m_cyc--;
        if (!top_allowed || m_cyc == 0) begin
          m_done = top_allowed;
          m_cyc  = 0;
          if (m_ret) begin m_mode = M_RUN; m_lvl = N - 1; end
          else begin m_mode = M_STBY; m_lvl = 0; end
          m_ret = 0;
        end
      end
      M_CLEAN: begin
        m_cyc--;
        if (m_cyc == 0) begin m_mode = M_STBY; m_done = 1; end
      end
      default: m_mode = M_OFF;
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e          = '0;
    e.cleaning = (m_mode == M_CLEAN);
    e.armed    = m_armed;
    e.done     = m_done;
    if (m_mode == M_TOP || m_mode == M_CLEAN) e.secs = 8'((m_cyc + CLK_HZ - 1) / CLK_HZ);
    case (m_mode)
      M_STBY:  e.led[0] = 1'b1;
      M_RUN:   begin e.level = LW'(m_lvl); e.led[m_lvl] = 1'b1; end
      M_TOP:   begin e.level = LW'(N); e.led[N] = 1'b1; end
      M_CLEAN: e.led[N+1] = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // Called at a negedge with inputs already set: queue the expected result, advance a cycle.
  task automatic step();
    model_step();
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input bit m, input bit [N-1:0] l, input bit c);
    menu_btn = m; level_btn = l; clean_btn = c;
    step();
    menu_btn = 0; level_btn = '0; clean_btn = 0;
    step();
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every clock the DUT presents a new output set; compare against the queue head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a = {level, cleaning, menu_armed, secs_left, led, done_pulse};
        tests++;
        if (mon_a !== mon_e) begin
          fails++;
          if (fails <= 20)
            $display("FAIL scoreboard t=%0t actual lvl=%0d cl=%b arm=%b secs=%0d led=%b done=%b required lvl=%0d cl=%b arm=%b secs=%0d led=%b done=%b",
                     $time, mon_a.level, mon_a.cleaning, mon_a.armed, mon_a.secs, mon_a.led,
                     mon_a.done, mon_e.level, mon_e.cleaning, mon_e.armed, mon_e.secs,
                     mon_e.led, mon_e.done);
        end
      end
    end
  end

  initial begin
    int n;
    @(negedge clk);
    idle(3);
    // Power-up into standby
    rst = 1; power_on = 1; top_allowed = 1;
    idle(3);
    chk("t1_led", led, 5'b00001);
    chk("t1_level", level, 0);
    chk("t1_secs", secs_left, 0);

    // Menu-armed level selection, level change in RUN, menu back to standby
    press(1, 3'b000, 0);
    press(0, 3'b001, 0);
    idle(1);
    chk("t2_level1", level, 1);
    chk("t2_led1", led, 5'b00010);
    press(0, 3'b010, 0);
    idle(1);
    chk("t2_level2", level, 2);
    press(1, 3'b000, 0);
    idle(2);
    chk("t2_standby", level, 0);

    // Hurricane without and with a return request
    press(1, 3'b000, 0);
    press(0, 3'b100, 0);
    chk("t3_level3", level, 3);
    chk("t3_secs", secs_left, 3);
    idle(35);
    chk("t3_expire_led", led, 5'b00001);
    press(1, 3'b000, 0);
    press(0, 3'b100, 0);
    idle(5);
    press(1, 3'b000, 0);
    idle(35);
    chk("t3_return_level", level, 2);
    press(1, 3'b000, 0);
    idle(2);

    // Self-clean ignores buttons and returns to standby
    press(1, 3'b000, 0);
    press(0, 3'b000, 1);
    chk("t4_cleaning", cleaning, 1);
    chk("t4_led", led, 5'b10000);
    press(0, 3'b001, 0);
    press(1, 3'b000, 0);
    idle(50);
    chk("t4_end_led", led, 5'b00001);

    // Same-cycle level/clean priority and held-button single action
    press(1, 3'b000, 0);
    level_btn = 3'b001; clean_btn = 1;
    step();
    clean_btn = 0;
    idle(3);
    chk("t5_level1", level, 1);
    level_btn = 3'b011;
    idle(3);
    chk("t5_held", level, 2);
    level_btn = '0;
    press(1, 3'b000, 0);
    idle(2);

    // Power drop mid-clean, re-power, reset mid-hurricane
    press(1, 3'b000, 0);
    press(0, 3'b000, 1);
    n = 0;
    while (secs_left != 8'd2 && n < 100) begin step(); n++; end
    chk("t6_wait_secs2", secs_left, 2);
    power_on = 0;
    idle(2);
    chk("t6_off_led", led, 0);
    chk("t6_off_secs", secs_left, 0);
    power_on = 1;
    idle(2);
    chk("t6_repower_led", led, 5'b00001);
    press(1, 3'b000, 0);
    press(0, 3'b100, 0);
    idle(5);
    rst = 0;
    step();
    rst = 1;
    idle(3);
    chk("t6_rst_led", led, 5'b00001);
    chk("t6_rst_secs", secs_left, 0);
    chk("t6_rst_level", level, 0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) menu_btn = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 3) == 0) level_btn[k] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) clean_btn = ($urandom_range(0, 4) == 0);
      power_on = ($urandom_range(0, 399) != 0);
      if (top_allowed) top_allowed = ($urandom_range(0, 149) != 0);
      else top_allowed = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 999) != 0);
      step();
    end

    rst = 1; power_on = 1; menu_btn = 0; level_btn = '0; clean_btn = 0;
    idle(2);
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
